// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package nsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/four_bit_adder.sv
// The lab's 4-bit ripple-carry adder; one full-adder cell per bit.
module four_bit_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C0,
  output logic [3:0] S,
  output logic       C4
);

  logic [4:0] c;

  assign c[0] = C0;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign C4 = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide unsigned add computed one nibble per cycle by reusing a single four_bit_adder,
// least significant nibble first, with the carry chained through a register.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      cout
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t          state;
  logic [W-1:0]    ra;
  logic [W-1:0]    rb;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [3:0]      s;
  logic            c4;

  four_bit_adder u_adder (
    .A  (ra[3:0]),
    .B  (rb[3:0]),
    .C0 (carry),
    .S  (s),
    .C4 (c4)
  );

  // Each RUN edge consumes the low nibble of ra/rb and pushes the partial sum in from the top,
  // so after NIBBLES edges the first nibble computed has reached sum[3:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            carry <= cin;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          ra    <= {4'b0000, ra[W-1:4]};
          rb    <= {4'b0000, rb[W-1:4]};
          sum   <= {s, sum[W-1:4]};
          carry <= c4;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NIBBLES - 1)) begin
            cout  <= c4;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: 16-bit and 8-bit instances, table vectors plus
// back-to-back start, mid-run reset and latency/handshake sequences.
module tb_nibble_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start4 = 1'b0;
  logic [15:0] a4 = '0;
  logic [15:0] b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4;
  logic        done4;
  logic [15:0] sum4;
  logic        cout4;

  logic        start2 = 1'b0;
  logic [7:0]  a2 = '0;
  logic [7:0]  b2 = '0;
  logic        cin2 = 1'b0;
  logic        busy2;
  logic        done2;
  logic [7:0]  sum2;
  logic        cout2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  nibble_serial_adder #(.NIBBLES(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one 16-bit add, scramble the operands after acceptance, and measure the
  // number of edges to done and the number of sampled cycles with busy high.
  task automatic run4(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                      output logic [15:0] rs, output logic rc, output int lat, output int bcnt);
    @(negedge clk);
    a4 = va; b4 = vb; cin4 = vc; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = ~va; b4 = 16'h5A5A; cin4 = ~vc;
    lat = 0; bcnt = 0;
    while (lat < 20) begin
      if (busy4) bcnt++;
      if (done4) break;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 20) check("done_timeout", 32'(lat), 32'd4);
    rs = sum4; rc = cout4;
    @(posedge clk); #1;
    check("done_pulse_width", 32'(done4), 32'd0);
    check("busy_fall", 32'(busy4), 32'd0);
  endtask

  vec_t        vecs[7];
  logic [15:0] rs;
  logic        rc;
  int          lat, bcnt;
  logic [16:0] exp_hist[18];
  logic        prev_done;

  initial begin
    vecs[0] = '{16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h1B3C, 16'h2747, 1'b0, 16'h4283, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_sum", 32'(sum4), 32'd0);
    check("reset_cout", 32'(cout4), 32'd0);
    check("reset_busy", 32'(busy4), 32'd0);
    check("reset_done", 32'(done4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run4(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat, bcnt);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].c));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd5);
    end

    // start held high: only operands present on accepting edges 0, 6, 12 count
    prev_done = 1'b0;
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      a4 = 16'h0F0F + 16'(n * 16'h0123);
      b4 = 16'hF00F + 16'(n * 16'h0457);
      cin4 = n[0];
      exp_hist[n] = {1'b0, a4} + {1'b0, b4} + {16'd0, cin4};
      start4 = 1'b1;
      @(posedge clk); #1;
      if (n % 6 == 4) begin
        check($sformatf("stream_done_e%0d", n), 32'(done4), 32'd1);
        check($sformatf("stream_sum_e%0d", n), 32'(sum4), 32'(exp_hist[n-4][15:0]));
        check($sformatf("stream_cout_e%0d", n), 32'(cout4), 32'(exp_hist[n-4][16]));
      end else begin
        check($sformatf("stream_nodone_e%0d", n), 32'(done4), 32'd0);
      end
      if (prev_done) check("stream_done_repeat", 32'(done4), 32'd0);
      prev_done = done4;
    end
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a run must wipe everything, including the held cout
    run4(16'hFFFF, 16'hFFFF, 1'b1, rs, rc, lat, bcnt);
    @(negedge clk);
    a4 = 16'h00FF; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("midrun_busy", 32'(busy4), 32'd1);
    check("midrun_partial_sum", 32'(sum4), 32'h00FF);
    rst_n = 1'b0;
    #1;
    check("async_reset_sum", 32'(sum4), 32'd0);
    check("async_reset_cout", 32'(cout4), 32'd0);
    check("async_reset_busy", 32'(busy4), 32'd0);
    check("async_reset_done", 32'(done4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run4(16'h0001, 16'h0001, 1'b0, rs, rc, lat, bcnt);
    check("post_reset_sum", 32'(rs), 32'h0002);
    check("post_reset_cout", 32'(rc), 32'd0);
    check("post_reset_latency", 32'(lat), 32'd4);

    // Two-nibble instance
    @(negedge clk);
    a2 = 8'hFF; b2 = 8'h01; cin2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; a2 = 8'h00; b2 = 8'h00; cin2 = 1'b0;
    check("n2_busy_rise", 32'(busy2), 32'd1);
    @(posedge clk); #1;
    check("n2_nodone_e1", 32'(done2), 32'd0);
    @(posedge clk); #1;
    check("n2_done_e2", 32'(done2), 32'd1);
    check("n2_sum", 32'(sum2), 32'h01);
    check("n2_cout", 32'(cout2), 32'd1);
    @(posedge clk); #1;
    check("n2_done_clear", 32'(done2), 32'd0);
    check("n2_busy_fall", 32'(busy2), 32'd0);
    check("n2_sum_hold", 32'(sum2), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
